// File: rtl/lane_pkg.sv
// Shared lane types and helpers for the 8-lane fan-out/fan-in datapath blocks.
package lane_pkg;

    localparam int unsigned LANE_MAX   = 8;
    localparam int unsigned LANE_IDX_W = 3;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;
    typedef logic [LANE_MAX-1:0]   lane_mask_t;

    // Round-robin successor: wraps to lane 0 after the last active lane.
    function automatic lane_idx_t next_lane(input lane_idx_t idx, input int unsigned port_num);
        if (32'(idx) + 32'd1 >= port_num) begin
            return '0;
        end
        return idx + lane_idx_t'(1);
    endfunction

    // One bit per lane below port_num.
    function automatic lane_mask_t active_mask(input int unsigned port_num);
        lane_mask_t m;
        m = '0;
        for (int unsigned i = 0; i < LANE_MAX; i++) begin
            if (i < port_num) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/lane_slot.sv
// One-entry holding register for a single output lane.
// A load wins over a drain, so a same-cycle load and drain keeps the slot full with new data.
module lane_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             drain,
    output logic [WIDTH-1:0] data_out,
    output logic             valid
);

    // Valid flag: set on load, cleared on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Data only changes on load; a drained lane keeps showing its last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (load) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/lane_distributor.sv
// 1-to-8 distributor: round-robin or broadcast of one word stream onto lanes a..h,
// each lane backed by a one-entry slot with its own valid/ready handshake.
module lane_distributor
    import lane_pkg::*;
#(
    parameter int unsigned Port_Num = 2,
    parameter int unsigned WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_bcast,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output lane_mask_t       out_valid,
    input  lane_mask_t       out_ready,
    output lane_idx_t        ptr,
    output logic             busy
);

    localparam lane_mask_t ACTIVE = active_mask(Port_Num);

    lane_mask_t       slot_free;
    lane_mask_t       load_en;
    lane_mask_t       drain_en;
    logic             rr_ready;
    logic             bcast_ready;
    logic             accept;
    logic [WIDTH-1:0] slot_data [LANE_MAX];

    // Ready/accept decode; the ready path passes straight through from out_ready.
    always_comb begin
        slot_free   = ~out_valid | out_ready;
        rr_ready    = slot_free[ptr];
        bcast_ready = &(slot_free | ~ACTIVE);
        in_ready    = in_bcast ? bcast_ready : rr_ready;
        accept      = in_valid & in_ready;
        drain_en    = out_valid & out_ready & ACTIVE;
        load_en     = '0;
        if (accept) begin
            if (in_bcast) begin
                load_en = ACTIVE;
            end else begin
                load_en = (lane_mask_t'(1) << ptr) & ACTIVE;
            end
        end
    end

    // Round-robin pointer advances only on round-robin accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && !in_bcast) begin
            ptr <= next_lane(ptr, Port_Num);
        end
    end

    // Eight lane slots; inactive lanes see a load enable masked to zero.
    for (genvar i = 0; i < LANE_MAX; i++) begin : g_lane
        lane_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load_en[i]),
            .data_in (in_data),
            .drain   (drain_en[i]),
            .data_out(slot_data[i]),
            .valid   (out_valid[i])
        );
    end

    // Lane data ports mirror the slot contents.
    always_comb begin
        a    = slot_data[0];
        b    = slot_data[1];
        c    = slot_data[2];
        d    = slot_data[3];
        e    = slot_data[4];
        f    = slot_data[5];
        g    = slot_data[6];
        h    = slot_data[7];
        busy = |out_valid;
    end

endmodule

// File: tb/tb_lane_distributor.sv
// Directed bench for lane_distributor: four instances (Port_Num 2,3,4,8) sharing stimulus.
module tb_lane_distributor;

    localparam int NDUT = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_bcast;
    logic [3:0] iv;
    logic [7:0] out_ready;
    logic       ir [NDUT];
    logic [7:0] ov [NDUT];
    logic [2:0] pt [NDUT];
    logic       bz [NDUT];
    logic [7:0] ln [NDUT][8];

    int n_chk;
    int n_fail;

    function automatic int pn_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 3 : (k == 2) ? 4 : 8;
    endfunction

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        lane_distributor #(
            .Port_Num((k == 0) ? 2 : (k == 1) ? 3 : (k == 2) ? 4 : 8),
            .WIDTH(8)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_data  (in_data),
            .in_bcast (in_bcast),
            .in_valid (iv[k]),
            .in_ready (ir[k]),
            .a        (ln[k][0]),
            .b        (ln[k][1]),
            .c        (ln[k][2]),
            .d        (ln[k][3]),
            .e        (ln[k][4]),
            .f        (ln[k][5]),
            .g        (ln[k][6]),
            .h        (ln[k][7]),
            .out_valid(ov[k]),
            .out_ready(out_ready),
            .ptr      (pt[k]),
            .busy     (bz[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        int       sel;
        bit       vld;
        bit       bc;
        bit [7:0] data;
        bit [7:0] ordy;
        bit       e_rdy;
        bit [7:0] e_ov;
        bit [2:0] e_ptr;
        int       lane;
        bit [7:0] e_lane;
        bit       all_en;
        bit [7:0] all_val;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input bit rst, input int sel, input bit vld, input bit bc,
                                input bit [7:0] data, input bit [7:0] ordy, input bit e_rdy,
                                input bit [7:0] e_ov, input bit [2:0] e_ptr, input int lane,
                                input bit [7:0] e_lane, input bit all_en, input bit [7:0] all_val);
        vec_t v;
        v.rst = rst; v.sel = sel; v.vld = vld; v.bc = bc; v.data = data; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_ptr = e_ptr; v.lane = lane; v.e_lane = e_lane;
        v.all_en = all_en; v.all_val = all_val;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        iv = '0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_bcast  = 1'b0;
        iv        = '0;
        out_ready = '0;
        n_chk     = 0;
        n_fail    = 0;

        // Port_Num=2 round-robin stream with all lanes draining
        vq.push_back(mk(1, 0, 1, 0, 8'h11, 8'hFF, 1, 8'h01, 3'd1, 0, 8'h11, 0, 8'h00));
        vq.push_back(mk(0, 0, 1, 0, 8'h22, 8'hFF, 1, 8'h02, 3'd0, 1, 8'h22, 0, 8'h00));
        vq.push_back(mk(0, 0, 1, 0, 8'h33, 8'hFF, 1, 8'h01, 3'd1, 0, 8'h33, 0, 8'h00));
        vq.push_back(mk(0, 0, 0, 0, 8'h00, 8'hFF, 1, 8'h00, 3'd1, 0, 8'h33, 0, 8'h00));
        // Port_Num=3 with all lanes stalled, then lane a released
        vq.push_back(mk(1, 1, 1, 0, 8'h01, 8'h00, 1, 8'h01, 3'd1, 0, 8'h01, 0, 8'h00));
        vq.push_back(mk(0, 1, 1, 0, 8'h02, 8'h00, 1, 8'h03, 3'd2, 1, 8'h02, 0, 8'h00));
        vq.push_back(mk(0, 1, 1, 0, 8'h03, 8'h00, 1, 8'h07, 3'd0, 2, 8'h03, 0, 8'h00));
        vq.push_back(mk(0, 1, 1, 0, 8'h04, 8'h00, 0, 8'h07, 3'd0, 0, 8'h01, 0, 8'h00));
        vq.push_back(mk(0, 1, 1, 0, 8'h04, 8'h00, 0, 8'h07, 3'd0, 0, 8'h01, 0, 8'h00));
        vq.push_back(mk(0, 1, 1, 0, 8'h04, 8'h01, 1, 8'h07, 3'd1, 0, 8'h04, 0, 8'h00));
        // Port_Num=4 broadcast keeps ptr, leaves e..h untouched
        vq.push_back(mk(1, 2, 1, 0, 8'h10, 8'hFF, 1, 8'h01, 3'd1, 0, 8'h10, 0, 8'h00));
        vq.push_back(mk(0, 2, 1, 1, 8'h5A, 8'hFF, 1, 8'h0F, 3'd1, 3, 8'h5A, 1, 8'h5A));
        vq.push_back(mk(0, 2, 0, 1, 8'h00, 8'hFF, 1, 8'h00, 3'd1, 2, 8'h5A, 1, 8'h5A));
        // Port_Num=4 broadcast blocked by stalled lane c
        vq.push_back(mk(1, 2, 1, 0, 8'h01, 8'h00, 1, 8'h01, 3'd1, 0, 8'h01, 0, 8'h00));
        vq.push_back(mk(0, 2, 1, 0, 8'h02, 8'h00, 1, 8'h03, 3'd2, 1, 8'h02, 0, 8'h00));
        vq.push_back(mk(0, 2, 1, 0, 8'h07, 8'h00, 1, 8'h07, 3'd3, 2, 8'h07, 0, 8'h00));
        vq.push_back(mk(0, 2, 1, 1, 8'h99, 8'h0B, 0, 8'h04, 3'd3, 2, 8'h07, 0, 8'h00));
        vq.push_back(mk(0, 2, 1, 1, 8'h99, 8'h0B, 0, 8'h04, 3'd3, 2, 8'h07, 0, 8'h00));
        vq.push_back(mk(0, 2, 1, 1, 8'h99, 8'h0F, 1, 8'h0F, 3'd3, 2, 8'h99, 1, 8'h99));
        // Port_Num=8 full wrap, 9 words
        for (int k = 0; k < 9; k++) begin
            vq.push_back(mk(k == 0, 3, 1, 0, 8'(8'h80 + k), 8'hFF, 1, 8'(1 << (k % 8)),
                            3'((k + 1) % 8), k % 8, 8'(8'h80 + k), 0, 8'h00));
        end

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            int   s;
            v = vq[i];
            s = v.sel;
            if (v.rst) begin
                pulse_reset();
                chk($sformatf("v%0d reset out_valid", i), 32'(ov[s]), 32'h0);
                chk($sformatf("v%0d reset ptr", i), 32'(pt[s]), 32'h0);
            end
            @(negedge clk);
            iv        = 4'(v.vld) << s;
            in_bcast  = v.bc;
            in_data   = v.data;
            out_ready = v.ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(ir[s]), 32'(v.e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(ov[s]), 32'(v.e_ov));
            chk($sformatf("v%0d ptr", i), 32'(pt[s]), 32'(v.e_ptr));
            chk($sformatf("v%0d busy", i), 32'(bz[s]), 32'(v.e_ov != 8'h00));
            chk($sformatf("v%0d lane%0d", i, v.lane), 32'(ln[s][v.lane]), 32'(v.e_lane));
            if (v.all_en) begin
                for (int l = 0; l < 8; l++) begin
                    chk($sformatf("v%0d all lane%0d", i, l), 32'(ln[s][l]),
                        (l < pn_of(s)) ? 32'(v.all_val) : 32'h0);
                end
            end
        end

        // Port_Num=2: fill both lanes stalled, then asynchronous reset mid-cycle
        pulse_reset();
        @(negedge clk);
        out_ready = 8'h00;
        in_bcast  = 1'b0;
        iv        = 4'b0001;
        in_data   = 8'hAA;
        @(negedge clk);
        in_data   = 8'hBB;
        @(negedge clk);
        in_data   = 8'hCC;
        #1;
        chk("rst full out_valid", 32'(ov[0]), 32'h03);
        chk("rst full in_ready", 32'(ir[0]), 32'h0);
        chk("rst full busy", 32'(bz[0]), 32'h1);
        chk("rst full b", 32'(ln[0][1]), 32'hBB);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(ov[0]), 32'h0);
        chk("async a", 32'(ln[0][0]), 32'h0);
        chk("async b", 32'(ln[0][1]), 32'h0);
        chk("async ptr", 32'(pt[0]), 32'h0);
        chk("async busy", 32'(bz[0]), 32'h0);
        iv = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        in_bcast = 1'b0;
        #1;
        chk("post rst in_ready rr", 32'(ir[0]), 32'h1);
        in_bcast = 1'b1;
        #1;
        chk("post rst in_ready bc", 32'(ir[0]), 32'h1);
        @(posedge clk);
        #1;
        chk("post rst no load", 32'(ov[0]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
